// File: rtl/cla_sum_accumulator.sv
// rtl/cla_sum_accumulator.sv - frame accumulator for the 4-bit CLA adder's 5-bit sum stream
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   upstream sum valid
//   in_ready   block can accept a sum this cycle (low only while holding a result)
//   in_sum     unsigned sum from the CLA stage (IN_W bits)
//   flush      close the current frame early (sampled only while accumulating)
//   out_valid  frame result valid
//   out_ready  downstream takes the result
//   out_acc    frame total (ACC_W bits)
//   out_cnt    number of sums in the frame (CW bits)
//   out_ovf    sticky overflow flag for the frame
//   busy       high while accumulating or holding a result
//
// Optional feature macro: CLA_ACC_SATURATE_EN
//   defined   - accumulator clamps to 2^ACC_W-1 on overflow for the rest of the frame
//   undefined - accumulator wraps modulo 2^ACC_W

module cla_sum_accumulator #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 8,
    parameter int COUNT = 16,
    parameter int CW    = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CW-1:0]    out_cnt,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [CW-1:0] COUNT_C = CW'(COUNT);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;

    state_t           w_state_nxt;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_ovf_nxt;

    logic             w_accept;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_add;
    logic [CW-1:0]    w_cnt_inc;

    // Accumulator, counter and flag are zero whenever the FSM is in IDLE,
    // so the first accept of a frame can share the ACCUM add path.
    always_comb begin
        w_accept  = in_valid && (r_state != S_HOLD);
        w_sum     = {1'b0, r_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, in_sum};
        w_carry   = w_sum[ACC_W];
        w_cnt_inc = r_cnt + CW'(1);
`ifdef CLA_ACC_SATURATE_EN
        // Once clamped the frame stays pinned at full scale.
        w_acc_add = (w_carry || r_ovf) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
        w_acc_add = w_sum[ACC_W-1:0];
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_acc_nxt   = w_acc_add;
                    w_cnt_nxt   = w_cnt_inc;
                    w_ovf_nxt   = r_ovf | w_carry;
                    w_state_nxt = (w_cnt_inc == COUNT_C) ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt = w_acc_add;
                    w_cnt_nxt = w_cnt_inc;
                    w_ovf_nxt = r_ovf | w_carry;
                    if ((w_cnt_inc == COUNT_C) || flush) begin
                        w_state_nxt = S_HOLD;
                    end
                end else if (flush) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
                w_ovf_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // All outputs decode registered state only.
    assign in_ready  = (r_state != S_HOLD);
    assign out_valid = (r_state == S_HOLD);
    assign busy      = (r_state != S_IDLE);
    assign out_acc   = r_acc;
    assign out_cnt   = r_cnt;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_cla_sum_accumulator.sv
// tb/tb_cla_sum_accumulator.sv - scoreboard bench for cla_sum_accumulator

module tb_cla_sum_accumulator;

    localparam int IN_W  = 5;
    localparam int ACC_W = 8;
    localparam int COUNT = 16;
    localparam int CW    = $clog2(COUNT + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sum;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CW-1:0]    out_cnt;
    logic             out_ovf;
    logic             busy;

    always #5 clk = ~clk;

    cla_sum_accumulator #(
        .IN_W (IN_W),
        .ACC_W(ACC_W),
        .COUNT(COUNT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sum   (in_sum),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_cnt  (out_cnt),
        .out_ovf  (out_ovf),
        .busy     (busy)
    );

    typedef struct {
        int acc;
        int cnt;
        int ovf;
    } frame_t;

    frame_t sb[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     m_acc   = 0;
    int     m_cnt   = 0;
    int     m_ovf   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 0;
    endtask

    task automatic model_close();
        frame_t f;
        f.acc = m_acc;
        f.cnt = m_cnt;
        f.ovf = m_ovf;
        sb.push_back(f);
        model_clear();
    endtask

    // One clock: the consume handshake is judged on pre-edge values, then
    // outputs are sampled 1 time unit after the edge.
    task automatic tick();
        frame_t f;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_frame", 1, 0);
            end else begin
                f = sb.pop_front();
                chk("sb_acc", int'(out_acc), f.acc);
                chk("sb_cnt", int'(out_cnt), f.cnt);
                chk("sb_ovf", int'(out_ovf), f.ovf);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input logic fl);
        int s;
        chk("send_in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_sum   = IN_W'(x);
        flush    = fl;
        m_cnt++;
        s = m_acc + x;
        if (s > 255) begin
            m_ovf = 1;
`ifdef CLA_ACC_SATURATE_EN
            m_acc = 255;
`else
            m_acc = s - 256;
`endif
        end else begin
            m_acc = s;
        end
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        if (m_cnt == COUNT || fl) model_close();
    endtask

    task automatic flush_only();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_close();
    endtask

    task automatic drain();
        int budget;
        out_ready = 1'b1;
        budget = 0;
        while (sb.size() != 0 && budget < 40) begin
            tick();
            budget++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sum    = 5'd3;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset with in_valid asserted
        tick();
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_acc", int'(out_acc), 0);
        chk("rst_out_cnt", int'(out_cnt), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("post_rst_in_ready", int'(in_ready), 1);
        chk("post_rst_cnt", int'(out_cnt), 0);

        // flush is ignored in IDLE
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("idle_flush_busy", int'(busy), 0);
        chk("idle_flush_valid", int'(out_valid), 0);

        // Full frame of 16 x 5
        out_ready = 1'b1;
        for (int i = 0; i < COUNT - 1; i++) send(5, 1'b0);
        chk("full_not_yet_valid", int'(out_valid), 0);
        chk("full_busy", int'(busy), 1);
        send(5, 1'b0);
        chk("full_valid", int'(out_valid), 1);
        chk("full_acc", int'(out_acc), 80);
        chk("full_cnt", int'(out_cnt), 16);
        chk("full_ovf", int'(out_ovf), 0);
        chk("full_in_ready", int'(in_ready), 0);
        drain();
        chk("full_idle_valid", int'(out_valid), 0);
        chk("full_idle_busy", int'(busy), 0);
        chk("full_idle_acc", int'(out_acc), 0);

        // Overflow: 16 x 31
        for (int i = 0; i < COUNT; i++) send(31, 1'b0);
`ifdef CLA_ACC_SATURATE_EN
        chk("ovf_acc", int'(out_acc), 255);
`else
        chk("ovf_acc", int'(out_acc), 240);
`endif
        chk("ovf_flag", int'(out_ovf), 1);
        drain();
        chk("ovf_cleared", int'(out_ovf), 0);

        // Backpressure
        out_ready = 1'b0;
        for (int i = 0; i < COUNT; i++) send(2, 1'b0);
        in_valid = 1'b1;
        in_sum   = 5'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_acc", int'(out_acc), 32);
            chk("bp_cnt", int'(out_cnt), 16);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_consumed", sb.size(), 0);
        chk("bp_restart_cnt", int'(out_cnt), 0);
        chk("bp_restart_acc", int'(out_acc), 0);
        send(7, 1'b0);
        flush_only();
        drain();

        // Flush with accept, then flush alone
        send(10, 1'b0);
        send(20, 1'b0);
        send(30, 1'b1);
        chk("flush_acc", int'(out_acc), 60);
        chk("flush_cnt", int'(out_cnt), 3);
        drain();
        send(4, 1'b0);
        send(4, 1'b0);
        flush_only();
        chk("flush2_acc", int'(out_acc), 8);
        chk("flush2_cnt", int'(out_cnt), 2);
        drain();

        // Mid-frame reset
        for (int i = 0; i < 5; i++) send(9, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        chk("midrst_cnt", int'(out_cnt), 0);
        chk("midrst_acc", int'(out_acc), 0);
        chk("midrst_busy", int'(busy), 0);
        for (int i = 0; i < COUNT; i++) send(1, 1'b0);
        chk("midrst_acc_full", int'(out_acc), 16);
        chk("midrst_cnt_full", int'(out_cnt), 16);
        chk("midrst_ovf", int'(out_ovf), 0);
        drain();
        chk("sb_empty_end", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
